// File: rtl/washer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : washer_pkg
//  Description : Shared types and constants for the washer actuator path.
//                Controller state encoding, fault codes reported back to
//                cycle_control, and the bit position of each actuator inside
//                the 4-bit command/drive vector {wash, rinse, spin, drain}.
//  Revision    : 1.0  initial release
// ============================================================================
package washer_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DEAD      = 2'd1,
    INTERLOCK = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_MULTI     = 2'b01;
  localparam logic [1:0] FC_INTERLOCK = 2'b10;
  localparam logic [1:0] FC_OVERFILL  = 2'b11;

  localparam int WASH  = 3;
  localparam int RINSE = 2;
  localparam int SPIN  = 1;
  localparam int DRAIN = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : washer_pkg
`default_nettype wire

// File: rtl/cmd_onehot_check.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_onehot_check
//  Description : Combinational classifier for a 4-bit actuator command.
//  Ports       : cmd        in  4  command vector {wash, rinse, spin, drain}
//                is_zero    out 1  no bit set
//                is_onehot  out 1  exactly one bit set
//                is_multi   out 1  two or more bits set
//  Revision    : 1.0  initial release
// ============================================================================
module cmd_onehot_check (
  input  logic [3:0] cmd,
  output logic       is_zero,
  output logic       is_onehot,
  output logic       is_multi
);

  logic w_seen;
  logic w_multi;

  // A bit arriving after another bit has already been seen means multi-hot;
  // done with plain gates so no adder/popcount is needed.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_multi = w_multi | (w_seen & cmd[i]);
      w_seen  = w_seen | cmd[i];
    end
  end

  assign is_zero   = ~w_seen;
  assign is_multi  = w_multi;
  assign is_onehot = w_seen & ~w_multi;

endmodule : cmd_onehot_check
`default_nettype wire

// File: rtl/actuator_driver.sv
`default_nettype none
// ============================================================================
//  Module      : actuator_driver
//  Description : Applies cycle_control actuator commands to the physical
//                drives with break-before-make dead-time, a drum-empty
//                interlock before spin, and rinse overfill protection.
//  Ports       : clk, rst (async, active low)
//                wash_motor_cmd / rinse_valve_cmd / spin_motor_cmd /
//                drain_valve_cmd   in   commands from cycle_control
//                water_sensor      in   8-bit unsigned water level
//                fault_clr         in   fault clear request (level)
//                *_drv             out  registered actuator drives
//                cmd_ack           out  one-cycle pulse when command applied
//                busy              out  dead-time or interlock in progress
//                fault, fault_code out  sticky fault flag and its cause
//  Revision    : 1.0  initial release
// ============================================================================
module actuator_driver
  import washer_pkg::*;
#(
  parameter int         DEAD_CYCLES       = 4,
  parameter int         INTERLOCK_TIMEOUT = 16,
  parameter logic [7:0] EMPTY_LEVEL       = 8'd20,
  parameter logic [7:0] OVERFILL_LEVEL    = 8'd230
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wash_motor_cmd,
  input  logic       rinse_valve_cmd,
  input  logic       spin_motor_cmd,
  input  logic       drain_valve_cmd,
  input  logic [7:0] water_sensor,
  input  logic       fault_clr,
  output logic       wash_motor_drv,
  output logic       rinse_valve_drv,
  output logic       spin_motor_drv,
  output logic       drain_valve_drv,
  output logic       cmd_ack,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int               CNT_W     = $clog2(max_int(DEAD_CYCLES, INTERLOCK_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ILK_LOAD  = CNT_W'(INTERLOCK_TIMEOUT - 1);
  localparam logic [3:0]       SPIN_VEC  = 4'b0010;

  logic [3:0] w_cmd;
  logic       w_zero;
  logic       w_onehot;
  logic       w_multi;

  state_t           r_state,  w_state_nxt;
  logic [3:0]       r_active, w_active_nxt;
  logic [3:0]       r_target, w_target_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt, w_cnt_dec;
  logic [3:0]       r_drv,    w_drv_nxt;
  logic             r_ack,    w_ack_nxt;
  logic [1:0]       r_code,   w_code_nxt;

  assign w_cmd = {wash_motor_cmd, rinse_valve_cmd, spin_motor_cmd, drain_valve_cmd};

  cmd_onehot_check u_check (
    .cmd       (w_cmd),
    .is_zero   (w_zero),
    .is_onehot (w_onehot),
    .is_multi  (w_multi)
  );

  assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_active <= 4'b0000;
      r_target <= 4'b0000;
      r_cnt    <= '0;
      r_drv    <= 4'b0000;
      r_ack    <= 1'b0;
      r_code   <= FC_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
      r_target <= w_target_nxt;
      r_cnt    <= w_cnt_nxt;
      r_drv    <= w_drv_nxt;
      r_ack    <= w_ack_nxt;
      r_code   <= w_code_nxt;
    end
  end

  // Drives are only ever loaded from r_active/r_target, which only ever hold
  // zero or a legal one-hot value, so at most one drive can be high.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_drv_nxt    = 4'b0000;
    w_ack_nxt    = 1'b0;
    w_code_nxt   = r_code;

    case (r_state)
      RUN: begin
        if (w_multi) begin
          w_state_nxt  = FAULT;
          w_code_nxt   = FC_MULTI;
          w_active_nxt = 4'b0000;
        end else if (r_active[RINSE] && (water_sensor >= OVERFILL_LEVEL)) begin
          w_state_nxt  = FAULT;
          w_code_nxt   = FC_OVERFILL;
          w_active_nxt = 4'b0000;
        end else if (w_cmd != r_active) begin
          // Break first: everything off, then count out the dead-time.
          w_state_nxt  = DEAD;
          w_target_nxt = w_cmd;
          w_cnt_nxt    = DEAD_LOAD;
          w_active_nxt = 4'b0000;
        end else begin
          w_drv_nxt = r_active;
        end
      end

      DEAD: begin
        if (w_multi) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_MULTI;
        end else if (w_cmd != r_target) begin
          w_target_nxt = w_cmd;
          w_cnt_nxt    = DEAD_LOAD;
        end else if (r_cnt == '0) begin
          if (r_target == 4'b0000) begin
            w_state_nxt  = RUN;
            w_active_nxt = 4'b0000;
            w_ack_nxt    = 1'b1;
          end else if (r_target[SPIN] && (water_sensor > EMPTY_LEVEL)) begin
            w_state_nxt = INTERLOCK;
            w_cnt_nxt   = ILK_LOAD;
          end else begin
            w_state_nxt  = RUN;
            w_active_nxt = r_target;
            w_drv_nxt    = r_target;
            w_ack_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end

      INTERLOCK: begin
        // A withdrawn spin request is honoured before the empty check so a
        // drum that empties in the same cycle never spins against the new cmd.
        if (w_multi) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_MULTI;
        end else if (!(w_onehot && w_cmd[SPIN])) begin
          w_state_nxt  = DEAD;
          w_target_nxt = w_cmd;
          w_cnt_nxt    = DEAD_LOAD;
        end else if (water_sensor <= EMPTY_LEVEL) begin
          w_state_nxt  = RUN;
          w_active_nxt = SPIN_VEC;
          w_drv_nxt    = SPIN_VEC;
          w_ack_nxt    = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_INTERLOCK;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end

      FAULT: begin
        if (fault_clr && w_zero) begin
          w_state_nxt  = RUN;
          w_active_nxt = 4'b0000;
          w_code_nxt   = FC_NONE;
        end
      end

      default: begin
        w_state_nxt  = FAULT;
        w_active_nxt = 4'b0000;
      end
    endcase
  end

  assign wash_motor_drv  = r_drv[WASH];
  assign rinse_valve_drv = r_drv[RINSE];
  assign spin_motor_drv  = r_drv[SPIN];
  assign drain_valve_drv = r_drv[DRAIN];
  assign cmd_ack         = r_ack;
  assign busy            = (r_state == DEAD) || (r_state == INTERLOCK);
  assign fault           = (r_state == FAULT);
  assign fault_code      = r_code;

endmodule : actuator_driver
`default_nettype wire

// File: tb/tb_actuator_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_actuator_driver
//  Description : Self-checking bench for actuator_driver. Table of per-cycle
//                {inputs, expected outputs} records plus hand-written
//                sequences for interlock timeout and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_actuator_driver;

  logic       clk;
  logic       rst;
  logic       wash_motor_cmd, rinse_valve_cmd, spin_motor_cmd, drain_valve_cmd;
  logic [7:0] water_sensor;
  logic       fault_clr;
  logic       wash_motor_drv, rinse_valve_drv, spin_motor_drv, drain_valve_drv;
  logic       cmd_ack, busy, fault;
  logic [1:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected-output scoreboard, filled when stimulus is driven.
  logic [8:0] sb[$];

  typedef struct {
    logic [3:0] cmd;
    logic [7:0] water;
    logic       clr;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  actuator_driver #(
    .DEAD_CYCLES       (4),
    .INTERLOCK_TIMEOUT (16),
    .EMPTY_LEVEL       (8'd20),
    .OVERFILL_LEVEL    (8'd230)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wash_motor_cmd  (wash_motor_cmd),
    .rinse_valve_cmd (rinse_valve_cmd),
    .spin_motor_cmd  (spin_motor_cmd),
    .drain_valve_cmd (drain_valve_cmd),
    .water_sensor    (water_sensor),
    .fault_clr       (fault_clr),
    .wash_motor_drv  (wash_motor_drv),
    .rinse_valve_drv (rinse_valve_drv),
    .spin_motor_drv  (spin_motor_drv),
    .drain_valve_drv (drain_valve_drv),
    .cmd_ack         (cmd_ack),
    .busy            (busy),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ex(input logic [3:0] d, input logic a, input logic b,
                                    input logic f, input logic [1:0] c);
    return {d, a, b, f, c};
  endfunction

  function automatic logic [8:0] actual();
    return {wash_motor_drv, rinse_valve_drv, spin_motor_drv, drain_valve_drv,
            cmd_ack, busy, fault, fault_code};
  endfunction

  task automatic check(input string nm, input logic [8:0] exp);
    logic [8:0] act;
    act = actual();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got drv=%b ack=%b busy=%b fault=%b code=%b, expected drv=%b ack=%b busy=%b fault=%b code=%b",
               nm, act[8:5], act[4], act[3], act[2], act[1:0],
               exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [7:0] w, input logic clr);
    {wash_motor_cmd, rinse_valve_cmd, spin_motor_cmd, drain_valve_cmd} = c;
    water_sensor = w;
    fault_clr    = clr;
  endtask

  // One clock edge: drive inputs, queue the expectation, compare after edge.
  task automatic step(input logic [3:0] c, input logic [7:0] w, input logic clr,
                      input logic [8:0] e, input string nm);
    drive(c, w, clr);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(nm, sb.pop_front());
  endtask

  function automatic void add(input logic [3:0] c, input logic [7:0] w, input logic clr,
                              input logic [3:0] d, input logic a, input logic b,
                              input logic f, input logic [1:0] code);
    vec_t v;
    v.cmd   = c;
    v.water = w;
    v.clr   = clr;
    v.exp   = ex(d, a, b, f, code);
    tbl.push_back(v);
  endfunction

  function automatic void add_dead(input logic [3:0] c, input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) add(c, w, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
  endfunction

  // Never two drives high at once, checked on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_checks++;
      if ($countones({wash_motor_drv, rinse_valve_drv, spin_motor_drv, drain_valve_drv}) > 1) begin
        n_fail++;
        $display("FAIL onehot_drives: got drv=%b, expected at most one bit set",
                 {wash_motor_drv, rinse_valve_drv, spin_motor_drv, drain_valve_drv});
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive(4'b0000, 8'd100, 1'b0);

    // wash from idle: 4 dead edges then drive+ack on the 5th
    add_dead(4'b1000, 8'd100, 4);
    add(4'b1000, 8'd100, 0, 4'b1000, 1, 0, 0, 2'b00);
    add(4'b1000, 8'd100, 0, 4'b1000, 0, 0, 0, 2'b00);
    // wash -> drain
    add_dead(4'b0001, 8'd100, 4);
    add(4'b0001, 8'd100, 0, 4'b0001, 1, 0, 0, 2'b00);
    // retarget mid dead-time restarts the count
    add_dead(4'b1000, 8'd100, 2);
    add_dead(4'b0001, 8'd100, 4);
    add(4'b0001, 8'd100, 0, 4'b0001, 1, 0, 0, 2'b00);
    // multi-hot from RUN, then clear
    add(4'b1010, 8'd100, 0, 4'b0000, 0, 0, 1, 2'b01);
    add(4'b0000, 8'd100, 1, 4'b0000, 0, 0, 0, 2'b00);
    // multi-hot mid dead-time; clear ignored while cmd nonzero
    add_dead(4'b1000, 8'd100, 2);
    add(4'b1010, 8'd100, 0, 4'b0000, 0, 0, 1, 2'b01);
    add(4'b0100, 8'd100, 1, 4'b0000, 0, 0, 1, 2'b01);
    add(4'b0000, 8'd100, 1, 4'b0000, 0, 0, 0, 2'b00);
    // rinse, overfill at exactly 230 (229 still fine)
    add_dead(4'b0100, 8'd100, 4);
    add(4'b0100, 8'd100, 0, 4'b0100, 1, 0, 0, 2'b00);
    add(4'b0100, 8'd229, 0, 4'b0100, 0, 0, 0, 2'b00);
    add(4'b0100, 8'd230, 0, 4'b0000, 0, 0, 1, 2'b11);
    add(4'b0010, 8'd100, 1, 4'b0000, 0, 0, 1, 2'b11);
    add(4'b0000, 8'd100, 1, 4'b0000, 0, 0, 0, 2'b00);
    // overfill beats a same-cycle command change
    add_dead(4'b0100, 8'd100, 4);
    add(4'b0100, 8'd100, 0, 4'b0100, 1, 0, 0, 2'b00);
    add(4'b1000, 8'd240, 0, 4'b0000, 0, 0, 1, 2'b11);
    add(4'b0000, 8'd100, 1, 4'b0000, 0, 0, 0, 2'b00);
    // spin held in interlock until drum drains
    add_dead(4'b0010, 8'd150, 4);
    add_dead(4'b0010, 8'd150, 3);
    add(4'b0010, 8'd10, 0, 4'b0010, 1, 0, 0, 2'b00);
    add(4'b0010, 8'd10, 0, 4'b0010, 0, 0, 0, 2'b00);
    // back to all-off: ack with no drive
    add_dead(4'b0000, 8'd150, 4);
    add(4'b0000, 8'd150, 0, 4'b0000, 1, 0, 0, 2'b00);
    // spin withdrawn while in interlock -> fresh dead-time to wash
    add_dead(4'b0010, 8'd150, 5);
    add_dead(4'b1000, 8'd150, 4);
    add(4'b1000, 8'd150, 0, 4'b1000, 1, 0, 0, 2'b00);
    add_dead(4'b0000, 8'd150, 4);
    add(4'b0000, 8'd150, 0, 4'b0000, 1, 0, 0, 2'b00);
    // water exactly at EMPTY_LEVEL counts as empty: no interlock wait
    add_dead(4'b0010, 8'd20, 4);
    add(4'b0010, 8'd20, 0, 4'b0010, 1, 0, 0, 2'b00);
    add_dead(4'b0000, 8'd20, 4);
    add(4'b0000, 8'd20, 0, 4'b0000, 1, 0, 0, 2'b00);

    #12;
    check("reset_state", ex(4'b0000, 0, 0, 0, 2'b00));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].cmd, tbl[i].water, tbl[i].clr, tbl[i].exp, $sformatf("tbl[%0d]", i));

    // Interlock timeout: 4 dead, 1 entry, 15 countdown, fault on the next.
    for (int i = 0; i < 20; i++)
      step(4'b0010, 8'd150, 1'b0, ex(4'b0000, 0, 1, 0, 2'b00), $sformatf("ilk_wait[%0d]", i));
    step(4'b0010, 8'd150, 1'b0, ex(4'b0000, 0, 0, 1, 2'b10), "ilk_timeout");
    step(4'b0010, 8'd10,  1'b0, ex(4'b0000, 0, 0, 1, 2'b10), "ilk_fault_held");
    step(4'b0000, 8'd10,  1'b1, ex(4'b0000, 0, 0, 0, 2'b00), "ilk_clear");

    // Async reset mid dead-time.
    step(4'b1000, 8'd100, 1'b0, ex(4'b0000, 0, 1, 0, 2'b00), "rst_pre_dead0");
    step(4'b1000, 8'd100, 1'b0, ex(4'b0000, 0, 1, 0, 2'b00), "rst_pre_dead1");
    #2 rst = 1'b0;
    #1 check("rst_async_dead", ex(4'b0000, 0, 0, 0, 2'b00));
    drive(4'b0010, 8'd0, 1'b0);
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++)
      step(4'b0010, 8'd0, 1'b0, ex(4'b0000, 0, 1, 0, 2'b00), $sformatf("rst_spin_dead[%0d]", i));
    step(4'b0010, 8'd0, 1'b0, ex(4'b0010, 1, 0, 0, 2'b00), "rst_spin_on");
    step(4'b0010, 8'd0, 1'b0, ex(4'b0010, 0, 0, 0, 2'b00), "rst_spin_hold");
    // Async reset mid spin.
    #2 rst = 1'b0;
    #1 check("rst_async_spin", ex(4'b0000, 0, 0, 0, 2'b00));
    drive(4'b0000, 8'd0, 1'b0);
    #3 rst = 1'b1;
    step(4'b0000, 8'd0, 1'b0, ex(4'b0000, 0, 0, 0, 2'b00), "post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_actuator_driver
`default_nettype wire

// File: doc/actuator_driver.md
Name: actuator_driver

Overview:
- Plant-side responder to cycle_control. Takes its four actuator commands (wash_motor, rinse_valve, spin_motor, drain_valve) and applies them safely to the physical actuator drives.
- Enforces break-before-make dead-time between actuators, a water-level interlock before spin, and rinse overfill protection.
- Returns a one-cycle ack when a command has been applied, plus a sticky fault indication back toward the controller.
- Sits between cycle_control and the actuator pins, alongside the water_level sensor path.

Parameters:
- DEAD_CYCLES, 4, all-off clock cycles inserted before any actuator is energized (>=1).
- INTERLOCK_TIMEOUT, 16, max cycles to wait for drum empty before spin faults (>=1).
- EMPTY_LEVEL, 8'd20, water_sensor value at or below which the drum counts as empty.
- OVERFILL_LEVEL, 8'd230, water_sensor value at or above which rinse is an overfill.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- wash_motor_cmd  in  1  command from cycle_control.
- rinse_valve_cmd  in  1  command from cycle_control.
- spin_motor_cmd  in  1  command from cycle_control.
- drain_valve_cmd  in  1  command from cycle_control.
- water_sensor  in  8  raw water level, unsigned.
- fault_clr  in  1  fault clear request, level.
- wash_motor_drv  out  1  actuator drive.
- rinse_valve_drv  out  1  actuator drive.
- spin_motor_drv  out  1  actuator drive.
- drain_valve_drv  out  1  actuator drive.
- cmd_ack  out  1  one-cycle pulse when the requested actuator is energized, or when all are de-energized for an all-zero command.
- busy  out  1  high in DEAD and INTERLOCK states.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 multi-hot command, 10 spin interlock timeout, 11 rinse overfill.

Behaviour:
- Reset (rst=0, async): all drives 0, cmd_ack 0, busy 0, fault 0, fault_code 00, state IDLE, active register = none, counter 0.
- Command vector cmd = {wash, rinse, spin, drain}, sampled every clk. Legal values are all-zero or one-hot. Registered "active" holds the currently applied one-hot vector or zero.
- Drives are registered. At most one drive is high in any cycle, under all conditions.
- States:
  - IDLE/ACTIVE (single state RUN): drives = active.
    - If cmd is multi-hot: go to FAULT, code 01.
    - Else if cmd != active: all drives 0 on the next edge, load counter with DEAD_CYCLES-1, go to DEAD, store cmd as target.
    - Else hold.
  - DEAD: drives all 0, counter decrements.
    - If cmd changes to a different legal value: update target, reload counter. Dead-time restarts.
    - Multi-hot cmd: go to FAULT, code 01.
    - At counter==0:
      - target zero: go to RUN with active=0, pulse cmd_ack.
      - target spin and water_sensor > EMPTY_LEVEL: go to INTERLOCK, counter = INTERLOCK_TIMEOUT-1.
      - otherwise: active=target, go to RUN, pulse cmd_ack on the same edge the drive rises.
  - INTERLOCK: drives 0. Each cycle:
    - water_sensor <= EMPTY_LEVEL: energize spin, go to RUN, pulse cmd_ack.
    - cmd no longer spin: return to DEAD with the new target and a fresh dead-time.
    - counter==0 with drum still not empty: go to FAULT, code 10.
  - FAULT: all drives 0, fault=1, code held. Exit to RUN with active=0 only when fault_clr=1 and cmd all-zero in the same cycle. fault_clr is ignored otherwise.
- Overfill: in RUN with active=rinse and water_sensor >= OVERFILL_LEVEL, rinse drive drops on the next edge and the block goes to FAULT, code 11. This has priority over a same-cycle command change.
- Priority within any cycle: reset > multi-hot > overfill > interlock/dead-time progression.
- Latency from command change to drive: DEAD_CYCLES+1 cycles minimum. The first edge clears the drives, then DEAD_CYCLES counts.
- No arithmetic other than the down-counter. Counter width = $clog2(max(DEAD_CYCLES, INTERLOCK_TIMEOUT))+1. Counter never wraps; it saturates at 0.

Decomposition:
- washer_pkg holds:
  - state enum {RUN, DEAD, INTERLOCK, FAULT};
  - fault_code localparams FC_NONE/FC_MULTI/FC_INTERLOCK/FC_OVERFILL;
  - actuator one-hot index constants (WASH=3, RINSE=2, SPIN=1, DRAIN=0).
- One natural sub-module: cmd_onehot_check (combinational, 4-bit in, outputs is_zero/is_onehot/is_multi). It is shared with any future controller-side self-check.

Test Plan:
1. Reset, cmd=0000, water=100. Raise wash_motor_cmd at t0 -> all drives 0 for 5 edges, wash_motor_drv=1 and cmd_ack pulse on the 5th edge (DEAD_CYCLES=4), busy high during the gap.
2. Active wash, switch cmd to drain -> wash drops on the next edge, 4 all-off cycles, then drain_valve_drv=1. No cycle ever has two drives high.
3. Request spin with water=150, lower water to 10 after 6 cycles -> spin held off in INTERLOCK, spin_motor_drv=1 one edge after water<=20, cmd_ack pulses. Repeat keeping water=150 -> after 16 cycles fault=1, code 10, all drives 0.
4. Active rinse, ramp water to 230 -> rinse_valve_drv=0 next edge, fault=1, code 11. Assert fault_clr with cmd=0010 -> stays in fault. Then fault_clr with cmd=0000 -> fault=0, code 00.
5. Drive cmd=1010 from RUN -> FAULT code 01 next edge, drives 0. Repeat during DEAD mid-count -> same result.
6. Assert rst low mid-dead-time and mid-spin -> all outputs 0 immediately (asynchronously). After release with cmd=spin and water=0, the full dead-time is applied before spin energizes.
